bitwise_logic_mc: RTL and testbench
===================================

# bitwise_logic_mc

Parametrised multi-cycle bitwise logic unit for the multi-cycle CPU datapath. It generalises the fixed 32-bit per-bit inverter to any width and eight logic operations, and processes operands one SLICE-bit slice per clock under a start/done handshake. It sits beside the arithmetic unit and is sequenced by the control FSM.

## Interface
Parameters:
- WIDTH, 32: operand and result width.
- SLICE, 8: bits processed per cycle. Must divide WIDTH and satisfy 1 ≤ SLICE ≤ WIDTH. NSLICE = WIDTH/SLICE.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when the unit is ready.
- op  in  3  000 NOT a, 001 AND, 010 OR, 011 XOR, 100 NOR, 101 NAND, 110 XNOR, 111 ANDN (a & ~b).
- a  in  WIDTH  operand A; ignored by no op except as noted.
- b  in  WIDTH  operand B; ignored for NOT.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result and zero are valid.
- result  out  WIDTH  registered result, held until the next completion.
- zero  out  1  high when result == 0; updated together with result.

## Operation
- Ready means state IDLE or DONE.
- FSM states and transitions:
  - IDLE: on start=1, latch a, b and op into operand registers, clear the slice counter, and go to RUN.
  - RUN: compute slice cnt into accum[cnt*SLICE +: SLICE] and increment cnt. When cnt == NSLICE-1, load result from the full accum (including this slice) and zero from it, then go to DONE.
  - DONE: done=1. On start=1, behave exactly as IDLE+start (back-to-back). Otherwise go to IDLE.
- start during RUN is ignored. Operands and op are not re-sampled, and the inputs may change freely while busy.
- Counter width is clog2(NSLICE), minimum 1 bit. cnt never exceeds NSLICE-1.
- result does not change between completions; the in-progress accum is internal only.
- Asynchronous reset, including mid-RUN: state IDLE, cnt 0, accum 0, result 0, zero 1, busy 0, done 0. The aborted operation is discarded and produces no done pulse.

## Timing
- Edge E0 samples start. busy is high from E0 to E_NSLICE. done, result and zero are visible in the cycle after E_NSLICE.
- Latency from the start-sampling edge to the done cycle is NSLICE cycles. WIDTH=32, SLICE=8 gives 4 cycles; SLICE=WIDTH gives 1 cycle.
- Sustained throughput is one operation per NSLICE+1 cycles, with start held high or reasserted in DONE.
- busy and done are never high in the same cycle.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package/header (alu_defs):
  - op encodings: OP_NOT .. OP_ANDN.
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Encoding 2'd3 is illegal and recovers to IDLE.
- One combinational sub-module, bitwise_slice #(SLICE): inputs op, a_s, b_s; output y_s. It is instantiated once and fed by a slice mux on cnt.
- The top level contains the FSM, counter, operand registers, accum, and the result/zero registers.

## Test plan
- NOT, a=0x0000FFFF, start one cycle → done exactly 4 cycles after the start edge, result=0xFFFF0000, zero=0; busy high for 4 cycles.
- AND, a=0xF0F0F0F0, b=0x0FF00FF0 → result=0x00F000F0. XOR with a=b=0x12345678 → result=0x00000000, zero=1.
- Start OR 0x1/0x2, then assert start with op=AND and new operands during RUN cycle 2 → single done, result=0x00000003; the second request is ignored.
- Back-to-back: hold start high with NOR a=0, b=0, then XNOR a=0xFFFF0000, b=0xFF00FF00 presented in the DONE cycle → done pulses 5 cycles apart, results 0xFFFFFFFF then 0xFF0000FF.
- Assert rst_n low asynchronously mid-RUN → outputs immediately show result=0, zero=1, busy=0, done=0, with no done pulse. A fresh NAND 0xFFFFFFFF/0xFFFFFFFF after reset → result 0, zero=1.
- Parameter sweep WIDTH=16, SLICE=16 and WIDTH=64, SLICE=4, with ANDN and random operands → latency is 1 and 16 cycles respectively, and results match the reference model.

Source files
------------

// File: rtl/bitwise_logic_mc_pkg.sv
// Shared definitions for the multi-cycle bitwise logic unit: op codes and FSM states.
package alu_defs;

    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_NOR  = 3'b100,
        OP_NAND = 3'b101,
        OP_XNOR = 3'b110,
        OP_ANDN = 3'b111
    } op_e;

    // 2'd3 is unused; the FSM falls back to IDLE if it ever appears.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bitwise_logic_mc_slice.sv
// Combinational SLICE-bit logic operation; one instance is time-shared across all slices.
module bitwise_slice
    import alu_defs::*;
#(
    parameter int SLICE = 8
) (
    input  logic [2:0]       op,
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    output logic [SLICE-1:0] y_s
);

    always_comb begin
        y_s = '0;
        case (op)
            OP_NOT:  y_s = ~a_s;
            OP_AND:  y_s = a_s & b_s;
            OP_OR:   y_s = a_s | b_s;
            OP_XOR:  y_s = a_s ^ b_s;
            OP_NOR:  y_s = ~(a_s | b_s);
            OP_NAND: y_s = ~(a_s & b_s);
            OP_XNOR: y_s = ~(a_s ^ b_s);
            OP_ANDN: y_s = a_s & ~b_s;
            default: y_s = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_mc.sv
// Multi-cycle bitwise logic unit: one SLICE-bit slice per clock under a start/done handshake.
module bitwise_logic_mc
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, accum, accum_nxt;
    logic [SLICE-1:0] a_s, b_s, y_s;
    logic             take, last;

    // A new request is only accepted when not mid-operation.
    assign take = start && (state_q == IDLE || state_q == DONE);
    assign last = (cnt == CW'(NSLICE - 1));

    assign a_s = a_q[cnt*SLICE +: SLICE];
    assign b_s = b_q[cnt*SLICE +: SLICE];

    bitwise_slice #(.SLICE(SLICE)) u_slice (
        .op  (op_q),
        .a_s (a_s),
        .b_s (b_s),
        .y_s (y_s)
    );

    // Final slice is folded in combinationally so result loads on the same edge.
    always_comb begin
        accum_nxt = accum;
        accum_nxt[cnt*SLICE +: SLICE] = y_s;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            accum   <= '0;
            result  <= '0;
            zero    <= 1'b1;
        end else begin
            state_q <= state_d;
            if (take) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
                cnt  <= '0;
            end else if (state_q == RUN) begin
                accum <= accum_nxt;
                if (last) begin
                    result <= accum_nxt;
                    zero   <= (accum_nxt == '0);
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_bitwise_logic_mc.sv
// Randomised self-checking bench for bitwise_logic_mc across three width/slice configurations.
module tb_bitwise_logic_mc;
    import alu_defs::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1, start2;
    logic [2:0]  op;
    logic [63:0] a, b;

    logic        busy0, done0, zero0;
    logic        busy1, done1, zero1;
    logic        busy2, done2, zero2;
    logic [31:0] result0;
    logic [15:0] result1;
    logic [63:0] result2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bitwise_logic_mc #(.WIDTH(32), .SLICE(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .op(op), .a(a[31:0]), .b(b[31:0]),
        .busy(busy0), .done(done0), .result(result0), .zero(zero0));

    bitwise_logic_mc #(.WIDTH(16), .SLICE(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op), .a(a[15:0]), .b(b[15:0]),
        .busy(busy1), .done(done1), .result(result1), .zero(zero1));

    bitwise_logic_mc #(.WIDTH(64), .SLICE(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op), .a(a), .b(b),
        .busy(busy2), .done(done2), .result(result2), .zero(zero2));

    // Reference: whole-word logic op, truncated to the unit's width.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] x,
                                          input logic [63:0] y, input int w);
        logic [63:0] r;
        logic [63:0] m;
        case (o)
            3'd0: r = ~x;
            3'd1: r = x & y;
            3'd2: r = x | y;
            3'd3: r = x ^ y;
            3'd4: r = ~(x | y);
            3'd5: r = ~(x & y);
            3'd6: r = ~(x ^ y);
            default: r = x & ~y;
        endcase
        m = (64'd1 << w) - 64'd1;
        return r & m;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Issues one request to the chosen unit and measures latency and busy cycles.
    task automatic run_op(input int which, input logic [2:0] o, input logic [63:0] x,
                          input logic [63:0] y, output int lat, output int bcnt,
                          output logic [63:0] res, output logic z, output logic tmo);
        logic bz, dn;
        int idx;
        @(negedge clk);
        op = o; a = x; b = y;
        case (which)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        idx = 1; bcnt = 0; tmo = 1'b1; lat = 0; res = '0; z = 1'b0;
        while (idx <= 40) begin
            case (which)
                0: begin bz = busy0; dn = done0; res = {32'd0, result0}; z = zero0; end
                1: begin bz = busy1; dn = done1; res = {48'd0, result1}; z = zero1; end
                default: begin bz = busy2; dn = done2; res = result2; z = zero2; end
            endcase
            if (bz) bcnt++;
            if (dn) begin
                tmo = 1'b0;
                lat = idx - 1;
                break;
            end
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start0 = 0; start1 = 0; start2 = 0; op = 0; a = 0; b = 0;
        #12;
        n_cmp++; if (result0 !== 32'd0 || zero0 !== 1'b1) begin n_err++;
            $display("FAIL reset_result0: got %h/%b want 0/1", result0, zero0); end
        n_cmp++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin n_err++;
            $display("FAIL reset_flags0: got busy=%b done=%b want 0/0", busy0, done0); end
        n_cmp++; if (result2 !== 64'd0 || zero1 !== 1'b1 || busy2 !== 1'b0) begin n_err++;
            $display("FAIL reset_others: got r2=%h z1=%b busy2=%b", result2, zero1, busy2); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_not();
        int lat, bc; logic [63:0] r; logic z, t;
        run_op(0, OP_NOT, 64'h0000FFFF, rnd64(), lat, bc, r, z, t);
        n_cmp++; if (t || lat != 4) begin n_err++;
            $display("FAIL not_latency: got %0d (timeout=%b) want 4", lat, t); end
        n_cmp++; if (bc != 4) begin n_err++;
            $display("FAIL not_busy_cycles: got %0d want 4", bc); end
        n_cmp++; if (r !== 64'hFFFF0000 || z !== 1'b0) begin n_err++;
            $display("FAIL not_result: got %h/%b want ffff0000/0", r, z); end
    endtask

    task automatic test_random_ops();
        int lat, bc; logic [63:0] r, x, y, e; logic z, t; logic [2:0] o;
        run_op(0, OP_AND, 64'hF0F0F0F0, 64'h0FF00FF0, lat, bc, r, z, t);
        n_cmp++; if (t || r !== 64'h00F000F0 || z !== 1'b0) begin n_err++;
            $display("FAIL and_directed: got %h/%b want 00f000f0/0", r, z); end
        run_op(0, OP_XOR, 64'h12345678, 64'h12345678, lat, bc, r, z, t);
        n_cmp++; if (t || r !== 64'd0 || z !== 1'b1) begin n_err++;
            $display("FAIL xor_zero: got %h/%b want 0/1", r, z); end
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 7));
            x = rnd64(); y = rnd64();
            if (i % 6 == 5) y = x;
            e = model(o, x, y, 32);
            run_op(0, o, x, y, lat, bc, r, z, t);
            n_cmp++; if (t || lat != 4 || r !== e || z !== (e == 64'd0)) begin n_err++;
                $display("FAIL rand_op%0d op=%0d: got %h/%b lat=%0d want %h/%b lat=4",
                         i, o, r, z, lat, e, (e == 64'd0)); end
        end
    endtask

    task automatic test_ignore_during_run();
        int dones; logic [31:0] r;
        dones = 0; r = '0;
        @(negedge clk);
        op = OP_OR; a = 64'h1; b = 64'h2; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        op = OP_AND; a = rnd64(); b = rnd64(); start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done0) begin dones++; r = result0; end
            @(negedge clk);
        end
        n_cmp++; if (dones != 1) begin n_err++;
            $display("FAIL ignore_done_count: got %0d want 1", dones); end
        n_cmp++; if (r !== 32'h3) begin n_err++;
            $display("FAIL ignore_result: got %h want 00000003", r); end
    endtask

    task automatic test_back_to_back();
        int got, first, second; logic [31:0] r1, r2;
        got = 0; first = 0; second = 0; r1 = '0; r2 = '0;
        @(negedge clk);
        op = OP_NOR; a = 0; b = 0; start0 = 1'b1;
        for (int i = 1; i <= 30 && got < 2; i++) begin
            @(negedge clk);
            if (busy0 && done0) begin n_cmp++; n_err++;
                $display("FAIL b2b_busy_done_overlap: got busy=1 done=1 want not both"); end
            if (done0) begin
                got++;
                if (got == 1) begin
                    first = i; r1 = result0;
                    op = OP_XNOR; a = 64'hFFFF0000; b = 64'hFF00FF00;
                end else begin
                    second = i; r2 = result0;
                end
            end
            if (got == 1 && i == first + 1) start0 = 1'b0;
        end
        start0 = 1'b0;
        n_cmp++; if (got != 2 || second - first != 5) begin n_err++;
            $display("FAIL b2b_spacing: got %0d dones %0d apart want 2 dones 5 apart",
                     got, second - first); end
        n_cmp++; if (r1 !== 32'hFFFFFFFF) begin n_err++;
            $display("FAIL b2b_nor: got %h want ffffffff", r1); end
        n_cmp++; if (r2 !== 32'hFF0000FF) begin n_err++;
            $display("FAIL b2b_xnor: got %h want ff0000ff", r2); end
    endtask

    task automatic test_async_reset();
        int dones, lat, bc; logic [63:0] r; logic z, t;
        dones = 0;
        @(negedge clk);
        op = OP_OR; a = rnd64() | 64'h1; b = rnd64(); start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (result0 !== 32'd0 || zero0 !== 1'b1) begin n_err++;
            $display("FAIL areset_result: got %h/%b want 0/1", result0, zero0); end
        n_cmp++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin n_err++;
            $display("FAIL areset_flags: got busy=%b done=%b want 0/0", busy0, done0); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (done0) dones++;
            @(negedge clk);
        end
        n_cmp++; if (dones != 0) begin n_err++;
            $display("FAIL areset_no_done: got %0d done pulses want 0", dones); end
        run_op(0, OP_NAND, 64'hFFFFFFFF, 64'hFFFFFFFF, lat, bc, r, z, t);
        n_cmp++; if (t || r !== 64'd0 || z !== 1'b1) begin n_err++;
            $display("FAIL areset_nand: got %h/%b want 0/1", r, z); end
    endtask

    task automatic test_param_sweep();
        int lat, bc; logic [63:0] r, x, y, e; logic z, t;
        for (int i = 0; i < 8; i++) begin
            x = rnd64(); y = rnd64();
            if (i == 0) y = x;
            e = model(OP_ANDN, x, y, 16);
            run_op(1, OP_ANDN, x, y, lat, bc, r, z, t);
            n_cmp++; if (t || lat != 1 || r !== e || z !== (e == 64'd0)) begin n_err++;
                $display("FAIL sweep16_%0d: got %h/%b lat=%0d want %h/%b lat=1",
                         i, r, z, lat, e, (e == 64'd0)); end
            e = model(OP_ANDN, x, y, 64);
            run_op(2, OP_ANDN, x, y, lat, bc, r, z, t);
            n_cmp++; if (t || lat != 16 || bc != 16 || r !== e || z !== (e == 64'd0)) begin n_err++;
                $display("FAIL sweep64_%0d: got %h/%b lat=%0d busy=%0d want %h/%b lat=16 busy=16",
                         i, r, z, lat, bc, e, (e == 64'd0)); end
        end
    endtask

    initial begin
        test_reset();
        test_not();
        test_random_ops();
        test_ignore_during_run();
        test_back_to_back();
        test_async_reset();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
